// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, depth, flag levels and data type for modport_fifo
package fifo_pkg;
  localparam int DATA_W        = 128;
  localparam int DEPTH         = 16;
  localparam int PTR_W         = $clog2(DEPTH);
  localparam int CNT_W         = PTR_W + 1;
  localparam int ALM_FULL_LVL  = 14;
  localparam int ALM_EMPTY_LVL = 2;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port register array, sync write, registered read
module fifo_mem
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  data_t            wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output data_t            rd_data
);

  data_t mem [DEPTH];

  // The array itself is never cleared; only the output register resets.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/modport_fifo.sv
// rtl/modport_fifo.sv - single-clock FIFO with full/almost-full/empty/almost-empty flags
module modport_fifo
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_wren,
  input  logic  i_rden,
  input  data_t i_wrdata,
  output logic  o_full,
  output logic  o_alm_full,
  output logic  o_empty,
  output logic  o_alm_empty,
  output data_t o_rddata
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance looks at flags decoded from the pre-edge count, so a
  // read+write while full only reads and while empty only writes.
  assign wr_acc = i_wren && !o_full;
  assign rd_acc = i_rden && !o_empty;

  assign o_full      = (count == CNT_W'(DEPTH));
  assign o_alm_full  = (count >= CNT_W'(ALM_FULL_LVL));
  assign o_empty     = (count == '0);
  assign o_alm_empty = (count <= CNT_W'(ALM_EMPTY_LVL));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_mem u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_wrdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (o_rddata)
  );

endmodule

// File: tb/tb_modport_fifo.sv
// tb/tb_modport_fifo.sv - directed self-checking bench for modport_fifo
module tb_modport_fifo;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_wren = 1'b0;
  logic         i_rden = 1'b0;
  logic [127:0] i_wrdata = '0;
  logic         o_full, o_alm_full, o_empty, o_alm_empty;
  logic [127:0] o_rddata;

  int errors = 0;
  int checks = 0;
  logic [127:0] sb [$];

  always #5 clk = ~clk;

  modport_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .i_wrdata    (i_wrdata),
    .o_full      (o_full),
    .o_alm_full  (o_alm_full),
    .o_empty     (o_empty),
    .o_alm_empty (o_alm_empty),
    .o_rddata    (o_rddata)
  );

  // Drive one cycle of requests, sample 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [127:0] d);
    i_wren = wr; i_rden = rd; i_wrdata = d;
    @(posedge clk); #1;
    i_wren = 1'b0; i_rden = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", o_empty); end
    checks++; if (o_alm_empty !== 1'b1) begin errors++; $display("FAIL rst_alm_empty: got %b want 1", o_alm_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", o_full); end
    checks++; if (o_alm_full !== 1'b0) begin errors++; $display("FAIL rst_alm_full: got %b want 0", o_alm_full); end
    checks++; if (o_rddata !== 128'h0) begin errors++; $display("FAIL rst_rddata: got %h want 0", o_rddata); end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b0, 128'(k));
    cyc(1'b0, 1'b1, '0);
    checks++; if (o_rddata !== 128'h1) begin errors++; $display("FAIL pre_rst_rddata: got %h want 1", o_rddata); end
    checks++; if (dut.count !== 5'd9) begin errors++; $display("FAIL pre_rst_count: got %0d want 9", dut.count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL async_empty: got %b want 1", o_empty); end
    checks++; if (o_alm_empty !== 1'b1) begin errors++; $display("FAIL async_alm_empty: got %b want 1", o_alm_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL async_full: got %b want 0", o_full); end
    checks++; if (o_alm_full !== 1'b0) begin errors++; $display("FAIL async_alm_full: got %b want 0", o_alm_full); end
    checks++; if (o_rddata !== 128'h0) begin errors++; $display("FAIL async_rddata: got %h want 0", o_rddata); end
    checks++; if (dut.count !== 5'd0) begin errors++; $display("FAIL async_count: got %0d want 0", dut.count); end
    reset = 1'b1;
  endtask

  task automatic test_underflow();
    cyc(1'b0, 1'b1, '0);
    checks++; if (o_rddata !== 128'h0) begin errors++; $display("FAIL uf_rddata: got %h want 0", o_rddata); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL uf_empty: got %b want 1", o_empty); end
    checks++; if (dut.rd_ptr !== 4'd0) begin errors++; $display("FAIL uf_rd_ptr: got %0d want 0", dut.rd_ptr); end
    checks++; if (dut.wr_ptr !== 4'd0) begin errors++; $display("FAIL uf_wr_ptr: got %0d want 0", dut.wr_ptr); end
    checks++; if (dut.count !== 5'd0) begin errors++; $display("FAIL uf_count: got %0d want 0", dut.count); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 128'(k));
      checks++; if (o_alm_empty !== (k <= 2)) begin errors++; $display("FAIL fill_alm_empty[%0d]: got %b want %b", k, o_alm_empty, (k <= 2)); end
      checks++; if (o_alm_full !== (k >= 14)) begin errors++; $display("FAIL fill_alm_full[%0d]: got %b want %b", k, o_alm_full, (k >= 14)); end
      checks++; if (o_full !== (k == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", k, o_full, (k == 16)); end
      checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b want 0", k, o_empty); end
    end
    cyc(1'b1, 1'b0, 128'hDEAD);
    checks++; if (dut.count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", dut.count); end
    checks++; if (dut.wr_ptr !== 4'd0) begin errors++; $display("FAIL ovf_wr_ptr: got %0d want 0", dut.wr_ptr); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", o_full); end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, '0);
      checks++; if (o_rddata !== 128'(k)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, o_rddata, 128'(k)); end
      checks++; if (o_alm_empty !== (16 - k <= 2)) begin errors++; $display("FAIL drain_alm_empty[%0d]: got %b want %b", k, o_alm_empty, (16 - k <= 2)); end
      checks++; if (o_empty !== (k == 16)) begin errors++; $display("FAIL drain_empty[%0d]: got %b want %b", k, o_empty, (k == 16)); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d]: got %b want 0", k, o_full); end
    end
    cyc(1'b0, 1'b1, '0);
    checks++; if (o_rddata !== 128'h10) begin errors++; $display("FAIL drain_extra_data: got %h want 10", o_rddata); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drain_extra_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_simul_empty();
    cyc(1'b1, 1'b1, 128'hA5A5);
    checks++; if (dut.count !== 5'd1) begin errors++; $display("FAIL se_count: got %0d want 1", dut.count); end
    checks++; if (o_rddata !== 128'h10) begin errors++; $display("FAIL se_rddata: got %h want 10", o_rddata); end
    checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL se_empty: got %b want 0", o_empty); end
    cyc(1'b0, 1'b1, '0);
    checks++; if (o_rddata !== 128'hA5A5) begin errors++; $display("FAIL se_read: got %h want a5a5", o_rddata); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL se_empty2: got %b want 1", o_empty); end
  endtask

  task automatic test_simul_steady();
    logic [127:0] exp, d;
    for (int k = 0; k < 5; k++) begin
      d = 128'h200 + 128'(k);
      cyc(1'b1, 1'b0, d);
      sb.push_back(d);
    end
    for (int k = 0; k < 20; k++) begin
      d = 128'h300 + 128'(k);
      cyc(1'b1, 1'b1, d);
      exp = sb.pop_front();
      sb.push_back(d);
      checks++; if (dut.count !== 5'd5) begin errors++; $display("FAIL ss_count[%0d]: got %0d want 5", k, dut.count); end
      checks++; if (o_rddata !== exp) begin errors++; $display("FAIL ss_data[%0d]: got %h want %h", k, o_rddata, exp); end
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, '0);
      exp = sb.pop_front();
      checks++; if (o_rddata !== exp) begin errors++; $display("FAIL ss_drain[%0d]: got %h want %h", k, o_rddata, exp); end
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL ss_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_simul_full();
    for (int k = 1; k <= 16; k++) cyc(1'b1, 1'b0, 128'h400 + 128'(k));
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL sf_full_pre: got %b want 1", o_full); end
    cyc(1'b1, 1'b1, 128'hBEEF);
    checks++; if (dut.count !== 5'd15) begin errors++; $display("FAIL sf_count: got %0d want 15", dut.count); end
    checks++; if (o_rddata !== 128'h401) begin errors++; $display("FAIL sf_rddata: got %h want 401", o_rddata); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL sf_full: got %b want 0", o_full); end
    for (int k = 2; k <= 16; k++) begin
      cyc(1'b0, 1'b1, '0);
      checks++; if (o_rddata !== 128'h400 + 128'(k)) begin errors++; $display("FAIL sf_drain[%0d]: got %h want %h", k, o_rddata, 128'h400 + 128'(k)); end
    end
    cyc(1'b0, 1'b1, '0);
    checks++; if (o_rddata !== 128'h410) begin errors++; $display("FAIL sf_dropped: got %h want 410", o_rddata); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL sf_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_wrap();
    logic [127:0] d, exp;
    logic wr, rd;
    int written = 0;
    int n = 0;
    while ((written < 40 || sb.size() > 0) && n < 400) begin
      wr = (written < 40) && (sb.size() < 12);
      rd = (written >= 40) ? (sb.size() > 0) : ((sb.size() > 3) && (n % 3 != 0));
      if (written == 5)       d = {128{1'b1}};
      else if (written == 10) d = '0;
      else                    d = {$urandom, $urandom, $urandom, $urandom};
      cyc(wr, rd, d);
      if (rd) begin
        exp = sb.pop_front();
        checks++; if (o_rddata !== exp) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", n, o_rddata, exp); end
      end
      if (wr) begin
        sb.push_back(d);
        written++;
      end
      checks++; if (dut.count !== 5'(sb.size())) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", n, dut.count, sb.size()); end
      n++;
    end
    checks++; if (n >= 400) begin errors++; $display("FAIL wrap_timeout: got %0d cycles want < 400", n); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", o_empty); end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_fill();
    test_drain();
    test_simul_empty();
    test_simul_steady();
    test_simul_full();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
